// File: rtl/i2s_audio_tx_pkg.sv
// rtl/i2s_audio_tx_pkg.sv - shared tiny-synth audio defaults and helpers
package i2s_audio_tx_pkg;

  // Synth-wide sample width and I2S slot width
  localparam int I2S_DATA_BITS_DEF = 12;
  localparam int I2S_SLOT_BITS_DEF = 16;
  localparam int I2S_CLK_DIV_DEF   = 4;

  // Counter width able to hold 0..n-1, never narrower than one bit
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// rtl/i2s_bclk_gen.sv - BCLK divider with fall/rise event strobes
module i2s_bclk_gen
  import i2s_audio_tx_pkg::*;
#(
  parameter int CLK_DIV = I2S_CLK_DIV_DEF
) (
  input  logic main_clk,
  input  logic rst_n,
  output logic bclk,
  output logic fall_evt,
  output logic rise_evt
);

  localparam int               DIV_W    = cnt_width(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  generate
    if (CLK_DIV < 1) begin : g_bad_div
      $error("i2s_bclk_gen: CLK_DIV must be at least 1");
    end
  endgenerate

  logic [DIV_W-1:0] div_q, div_d;
  logic             bclk_q, bclk_d;
  logic             tc;

  // Divider next state; bclk flips on the terminal count
  always_comb begin
    tc     = (div_q == DIV_LAST);
    div_d  = tc ? '0 : div_q + 1'b1;
    bclk_d = tc ? ~bclk_q : bclk_q;
  end

  // Divider and bclk registers
  always_ff @(posedge main_clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      bclk_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      bclk_q <= bclk_d;
    end
  end

  // Strobes are high in the cycle whose closing edge moves bclk
  assign bclk     = bclk_q;
  assign fall_evt = tc & bclk_q;
  assign rise_evt = tc & ~bclk_q;

endmodule

// File: rtl/i2s_audio_tx.sv
// rtl/i2s_audio_tx.sv - mono-to-stereo I2S transmitter with sample request strobe
module i2s_audio_tx
  import i2s_audio_tx_pkg::*;
#(
  parameter int DATA_BITS = I2S_DATA_BITS_DEF,
  parameter int SLOT_BITS = I2S_SLOT_BITS_DEF,
  parameter int CLK_DIV   = I2S_CLK_DIV_DEF
) (
  input  logic                 main_clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] sample_in,
  input  logic                 en,
  output logic                 sample_req,
  output logic                 i2s_bclk,
  output logic                 i2s_lrclk,
  output logic                 i2s_sdata
);

  localparam int               CNT_W    = cnt_width(SLOT_BITS);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(SLOT_BITS - 1);
  localparam int               PAD_BITS = SLOT_BITS - DATA_BITS;

  generate
    if (SLOT_BITS < DATA_BITS) begin : g_bad_slot
      $error("i2s_audio_tx: SLOT_BITS must be >= DATA_BITS");
    end
  endgenerate

  logic                 fall_evt, rise_evt;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                 lrclk_q, lrclk_d;
  logic                 sdata_q, sdata_d;
  logic                 req_q, req_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic [SLOT_BITS-1:0] shift_q, shift_d;
  logic                 lr_toggle, to_left;
  logic [DATA_BITS-1:0] new_sample, word_src;
  logic [SLOT_BITS-1:0] slot_word;

  i2s_bclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_bclk_gen (
    .main_clk (main_clk),
    .rst_n    (rst_n),
    .bclk     (i2s_bclk),
    .fall_evt (fall_evt),
    .rise_evt (rise_evt)
  );

  // The divider can never report both edges in one cycle
  assert property (@(posedge main_clk) disable iff (!rst_n) !(fall_evt && rise_evt));

  // Frame sequencing: everything moves on fall events; the shift register is
  // reloaded at the lrclk toggle, so the old slot's LSB goes out alongside the
  // toggle and the new MSB follows one BCLK later
  always_comb begin
    lr_toggle  = fall_evt && (bit_cnt_q == BIT_LAST);
    to_left    = lr_toggle && lrclk_q;
    new_sample = en ? sample_in : '0;
    word_src   = to_left ? new_sample : hold_q;
    slot_word  = SLOT_BITS'(word_src) << PAD_BITS;

    bit_cnt_d = bit_cnt_q;
    lrclk_d   = lrclk_q;
    sdata_d   = sdata_q;
    req_d     = 1'b0;
    hold_d    = hold_q;
    shift_d   = shift_q;

    if (fall_evt) begin
      bit_cnt_d = lr_toggle ? '0 : bit_cnt_q + 1'b1;
      sdata_d   = shift_q[SLOT_BITS-1];
      shift_d   = shift_q << 1;
      if (lr_toggle) begin
        lrclk_d = ~lrclk_q;
        shift_d = slot_word;
      end
      if (to_left) begin
        hold_d = new_sample;
        req_d  = 1'b1;
      end
    end
  end

  // Frame state registers
  always_ff @(posedge main_clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q <= '0;
      lrclk_q   <= 1'b0;
      sdata_q   <= 1'b0;
      req_q     <= 1'b0;
      hold_q    <= '0;
      shift_q   <= '0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      lrclk_q   <= lrclk_d;
      sdata_q   <= sdata_d;
      req_q     <= req_d;
      hold_q    <= hold_d;
      shift_q   <= shift_d;
    end
  end

  assign sample_req = req_q;
  assign i2s_lrclk  = lrclk_q;
  assign i2s_sdata  = sdata_q;

endmodule
